// File: rtl/vec_store_buffer.sv
// vec_store_buffer
//   Store buffer between the vector CPU memory stage and a single-port,
//   asynchronous-read vector data memory. Stores are queued in a circular
//   FIFO and drained one per cycle whenever a load does not need the port.
//   A full buffer always drains, so loads stall rather than starve drains.
//
//   Configuration macro: STBUF_FORWARD_EN
//     defined   - loads hitting a buffered store get the youngest entry data.
//     undefined - loads hitting a buffered store stall while the matching
//                 entries drain; ld_hit is tied to 0.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   st_valid/st_ready   store handshake; st_addr, st_data store payload
//   ld_req, ld_addr     load request; ld_stall holds the requester
//   ld_data, ld_hit     load result and "came from buffer" flag
//   mem_we/addr/wd      data memory write port / shared address
//   mem_rd              combinational data memory read data
//   count, empty        occupancy status
module vec_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int LANES  = 6,
    parameter int LANE_W = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               st_valid,
    output logic                               st_ready,
    input  logic [31:0]                        st_addr,
    input  logic [LANES-1:0][LANE_W-1:0]       st_data,
    input  logic                               ld_req,
    input  logic [31:0]                        ld_addr,
    output logic                               ld_stall,
    output logic [LANES-1:0][LANE_W-1:0]       ld_data,
    output logic                               ld_hit,
    output logic                               mem_we,
    output logic [31:0]                        mem_addr,
    output logic [LANES-1:0][LANE_W-1:0]       mem_wd,
    input  logic [LANES-1:0][LANE_W-1:0]       mem_rd,
    output logic [$clog2(DEPTH):0]             count,
    output logic                               empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [LANES-1:0][LANE_W-1:0] word_t;

    logic [31:0]   r_addr [DEPTH];
    word_t         r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_enq;
    logic          w_drain;
    logic          w_stall;
    logic          w_hit;
    logic          w_match;
    logic [PW-1:0] w_idx;
`ifdef STBUF_FORWARD_EN
    word_t         w_fwd_data;
`endif

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_enq   = st_valid && !w_full;

    // Walk entries oldest to youngest; later matches overwrite earlier ones,
    // so the surviving match is the youngest valid entry.
    always_comb begin
        w_match = 1'b0;
        w_idx   = '0;
`ifdef STBUF_FORWARD_EN
        w_fwd_data = '0;
`endif
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if ((CW'(i) < r_count) && (r_addr[w_idx][13:2] == ld_addr[13:2])) begin
                w_match = 1'b1;
`ifdef STBUF_FORWARD_EN
                w_fwd_data = r_data[w_idx];
`endif
            end
        end
    end

`ifdef STBUF_FORWARD_EN
    assign w_drain = w_full || (!ld_req && !w_empty);
    assign w_stall = ld_req && w_full;
    assign w_hit   = ld_req && !w_full && w_match;
    assign ld_data = w_hit ? w_fwd_data : mem_rd;
`else
    // A matching load must wait for memory to be up to date, so it hands
    // the port to the drain until no matching entry remains.
    assign w_drain = w_full || (!w_empty && (!ld_req || w_match));
    assign w_stall = ld_req && (w_full || w_match);
    assign w_hit   = 1'b0;
    assign ld_data = mem_rd;
`endif

    assign st_ready = !w_full;
    assign ld_stall = w_stall;
    assign ld_hit   = w_hit;
    assign count    = r_count;
    assign empty    = w_empty;

    // Gate with rst_n so no partial write escapes while reset is asserted.
    assign mem_we = rst_n && w_drain;
    assign mem_wd = mem_we ? r_data[r_head] : '0;

    always_comb begin
        mem_addr = '0;
        if (!rst_n)
            mem_addr = '0;
        else if (w_drain)
            mem_addr = r_addr[r_head];
        else if (ld_req)
            mem_addr = ld_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq)
                r_tail <= r_tail + 1'b1;
            if (w_drain)
                r_head <= r_head + 1'b1;
            r_count <= r_count + CW'(w_enq) - CW'(w_drain);
        end
    end

    // Entry payload needs no reset; occupancy is tracked by head/count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= st_addr;
            r_data[r_tail] <= st_data;
        end
    end

endmodule

// File: tb/tb_vec_store_buffer.sv
module tb_vec_store_buffer;

    localparam int DEPTH = 4;

`ifdef STBUF_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef logic [5:0][7:0] vec_t;
    typedef struct { logic [31:0] a; vec_t d; } ent_t;
    typedef struct { logic [31:0] a; vec_t d; bit hit; } ld_exp_t;
    typedef struct { int cnt; bit emp; bit rdy; bit stl; bit we; } st_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    vec_t        st_data = '0;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = '0;
    logic        ld_stall;
    vec_t        ld_data;
    logic        ld_hit;
    logic        mem_we;
    logic [31:0] mem_addr;
    vec_t        mem_wd;
    vec_t        mem_rd;
    logic [$clog2(DEPTH):0] count;
    logic        empty;

    vec_store_buffer #(.DEPTH(DEPTH), .LANES(6), .LANE_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_stall(ld_stall), .ld_data(ld_data), .ld_hit(ld_hit),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    // Data memory seen by the DUT, and the reference memory kept by the model.
    vec_t tb_mem  [4096];
    vec_t ref_mem [4096];
    assign mem_rd = tb_mem[ld_addr[13:2]];
    always @(posedge clk) if (mem_we) tb_mem[mem_addr[13:2]] <= mem_wd;

    // Reference model: program-order list of buffered stores.
    ent_t    mq[$];
    st_exp_t st_q[$];
    ent_t    wr_q[$];
    ld_exp_t ld_q[$];

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t rvec();
        vec_t v;
        for (int l = 0; l < 6; l++) v[l] = 8'($urandom());
        return v;
    endfunction

    function automatic vec_t fill(input logic [7:0] b);
        vec_t v;
        for (int l = 0; l < 6; l++) v[l] = b;
        return v;
    endfunction

    // Random address with a small word-index range so stores and loads alias.
    function automatic logic [31:0] raddr();
        logic [31:0] r;
        r = $urandom();
        r[13:2] = 12'($urandom_range(0, 7));
        return r;
    endfunction

    // One clock cycle: drive inputs, predict the cycle from the model, push
    // expectations, then advance the model past the rising edge.
    task automatic step(input bit sv, input logic [31:0] sa, input vec_t sd,
                        input bit lr, input logic [31:0] la, output bit stalled);
        int      n;
        bit      full, match, drain, stall, hit, enq;
        vec_t    yd;
        st_exp_t se;
        ld_exp_t le;
        n = mq.size();
        full = (n == DEPTH);
        match = 1'b0;
        yd = '0;
        for (int i = 0; i < n; i++)
            if (mq[i].a[13:2] == la[13:2]) begin match = 1'b1; yd = mq[i].d; end
        st_valid = sv; st_addr = sa; st_data = sd;
        ld_req = lr; ld_addr = la;
        if (FWD) begin
            drain = full || (!lr && n > 0);
            stall = lr && full;
            hit   = lr && !stall && match;
        end else begin
            drain = full || (n > 0 && (!lr || match));
            stall = lr && (full || match);
            hit   = 1'b0;
        end
        enq = sv && !full;
        se.cnt = n; se.emp = (n == 0); se.rdy = !full; se.stl = stall; se.we = drain;
        st_q.push_back(se);
        if (drain) wr_q.push_back(mq[0]);
        if (lr && !stall) begin
            le.a = la; le.hit = hit;
            le.d = hit ? yd : ref_mem[la[13:2]];
            ld_q.push_back(le);
        end
        @(posedge clk);
        if (drain) begin
            ref_mem[mq[0].a[13:2]] = mq[0].d;
            void'(mq.pop_front());
        end
        if (enq) mq.push_back('{a: sa, d: sd});
        #1;
        stalled = stall;
    endtask

    task automatic idle(input int n);
        bit s;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, s);
    endtask

    task automatic load_until(input logic [31:0] la);
        bit s;
        s = 1'b1;
        for (int k = 0; k < 16 && s; k++) step(1'b0, '0, '0, 1'b1, la, s);
        check("load_serviced_in_budget", 64'(s), 64'd0);
    endtask

    // Entered at posedge+1; leaves at the following posedge+1 with rst_n high.
    task automatic do_reset();
        rst_n = 1'b0;
        st_valid = 1'b0;
        ld_req = 1'b1;
        ld_addr = raddr();
        mq.delete();
        #1;
        check("rst_count",    64'(count),    64'd0);
        check("rst_empty",    64'(empty),    64'd1);
        check("rst_st_ready", 64'(st_ready), 64'd1);
        check("rst_mem_we",   64'(mem_we),   64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wd",   64'(mem_wd),   64'd0);
        check("rst_ld_hit",   64'(ld_hit),   64'd0);
        check("rst_ld_stall", 64'(ld_stall), 64'd0);
        check("rst_ld_data",  64'(ld_data),  64'(tb_mem[ld_addr[13:2]]));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ld_req = 1'b0;
    endtask

    // Monitor: compares whatever the DUT presents against queued expectations.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                check("we_during_reset", 64'(mem_we), 64'd0);
            end else begin
                if (st_q.size() == 0) begin
                    check("status_expected", 64'd0, 64'd1);
                end else begin
                    st_exp_t s;
                    s = st_q.pop_front();
                    check("count",    64'(count),    64'(s.cnt));
                    check("empty",    64'(empty),    64'(s.emp));
                    check("st_ready", 64'(st_ready), 64'(s.rdy));
                    check("ld_stall", 64'(ld_stall), 64'(s.stl));
                    check("mem_we",   64'(mem_we),   64'(s.we));
                end
                if (mem_we) begin
                    if (wr_q.size() == 0) begin
                        check("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        ent_t w;
                        w = wr_q.pop_front();
                        check("wr_addr", 64'(mem_addr), 64'(w.a));
                        check("wr_data", 64'(mem_wd),   64'(w.d));
                    end
                end
                if (ld_req && !ld_stall) begin
                    if (ld_q.size() == 0) begin
                        check("unexpected_load_service", 64'(ld_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        ld_exp_t l;
                        l = ld_q.pop_front();
                        check("ld_mem_addr", 64'(mem_addr), 64'(l.a));
                        check("ld_data",     64'(ld_data),  64'(l.d));
                        check("ld_hit",      64'(ld_hit),   64'(l.hit));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          s;
        bit          lr;
        logic [31:0] la;
        int          bad;
        for (int i = 0; i < 4096; i++) begin
            tb_mem[i]  = rvec();
            ref_mem[i] = tb_mem[i];
        end
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single store drains the cycle after it is enqueued.
        step(1'b1, 32'h10, {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, '0, s);
        idle(3);

        // Two stores to one word, then a load of that word.
        step(1'b1, 32'h20, fill(8'h01), 1'b1, 32'h1000, s);
        step(1'b1, 32'h20, fill(8'h09), 1'b1, 32'h1000, s);
        load_until(32'h20);
        idle(4);
        load_until(32'h20);

        // Word-index match ignores byte offset bits.
        step(1'b1, 32'h40, rvec(), 1'b1, 32'h1000, s);
        load_until(32'h43);
        load_until(32'h44);
        idle(3);

        // Fill the buffer behind non-matching loads, then keep loading.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h80 + 32'(4 * i), rvec(), 1'b1, 32'h1000, s);
        load_until(32'h1000);
        idle(6);

        // Back-to-back stores with no loads: wrap-around with enqueue+drain.
        for (int i = 0; i < 10; i++) step(1'b1, 32'(4 * i), rvec(), 1'b0, '0, s);
        idle(4);

        // Reset with three stores buffered: none of them may reach memory.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + 32'(4 * i), rvec(), 1'b1, 32'h1000, s);
        do_reset();
        idle(2);

        // Randomized traffic; a stalled load is held until serviced.
        s = 1'b0; lr = 1'b0; la = '0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 500) begin
                do_reset();
                s = 1'b0;
            end
            if (!s) begin
                lr = ($urandom_range(0, 99) < 40);
                la = raddr();
            end
            step($urandom_range(0, 99) < 55, raddr(), rvec(), lr, la, s);
        end
        idle(8);

        mon_en = 1'b0;
        check("pending_status", 64'(st_q.size()), 64'd0);
        check("pending_writes", 64'(wr_q.size()), 64'd0);
        check("pending_loads",  64'(ld_q.size()), 64'd0);
        bad = 0;
        for (int i = 0; i < 4096; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
        check("final_memory_words_differing", 64'(bad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vec_store_buffer.md
# vec_store_buffer

Store buffer between the vector CPU memory stage and the single-port vector data memory. It queues vector stores of six 8-bit lanes and drains them to memory one per cycle whenever the memory port is not needed by a load. Loads that hit a buffered store get the youngest buffered data through forwarding. The block decouples store issue from memory port contention without changing the program-order view of memory.

## Interface
Parameters:
- DEPTH, 4: number of buffered stores; a power of two, at least 2.
- LANES, 6: vector lanes per memory word.
- LANE_W, 8: bits per lane.

Ports:
- clk  in  1: clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- st_valid  in  1: store request.
- st_ready  out  1: buffer can accept a store this cycle.
- st_addr  in  32: store byte address.
- st_data  in  [LANES-1:0][LANE_W-1:0]: store data.
- ld_req  in  1: load request this cycle.
- ld_addr  in  32: load byte address.
- ld_stall  out  1: load not serviced this cycle; the requester holds ld_req and ld_addr.
- ld_data  out  [LANES-1:0][LANE_W-1:0]: load result, valid when ld_req=1 and ld_stall=0.
- ld_hit  out  1: ld_data came from the buffer.
- mem_we  out  1: write enable to data memory.
- mem_addr  out  32: address to data memory.
- mem_wd  out  [LANES-1:0][LANE_W-1:0]: write data to data memory.
- mem_rd  in  [LANES-1:0][LANE_W-1:0]: combinational read data from data memory.
- count  out  $clog2(DEPTH)+1: number of occupied entries.
- empty  out  1: count==0.

## Operation
- Circular FIFO with head and tail pointers and a count register. Each entry holds the 32-bit address and the lane data.
- Address match compares word index bits [13:2] only.
- Enqueue happens when st_valid && st_ready. st_ready = (count<DEPTH). It does not depend on a drain in the same cycle.
- Port arbitration each cycle, in priority order:
  1. full (count==DEPTH): drain head. If ld_req=1, assert ld_stall.
  2. ld_req=1: service the load. mem_we=0, mem_addr=ld_addr, no drain.
  3. !empty: drain head. mem_we=1, mem_addr=head.addr, mem_wd=head.data.
  4. Otherwise idle: mem_we=0, mem_addr=0.
- Load forwarding: among the valid entries, pick the youngest whose word index matches ld_addr[13:2]. If one exists, ld_data=entry data and ld_hit=1. Otherwise ld_data=mem_rd and ld_hit=0.
- Forwarding uses only entries present at the start of the cycle. A store being enqueued in the same cycle is not visible to that cycle's load.
- Simultaneous enqueue and drain: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Multiple entries with the same word index are allowed. Each is drained in order, so memory ends with the youngest value.

## Timing
- ld_data, ld_hit, ld_stall, mem_* and st_ready are combinational from registered state and the current inputs. Load latency is zero cycles, matching the asynchronous-read memory.
- An enqueued store occupies an entry from the next rising edge. The earliest it can drain to memory is the cycle after enqueue.
- A drain commits on the rising edge where mem_we=1. The entry is freed at that same edge.
- Reset (asynchronous, rst_n=0): head=tail=count=0, empty=1, st_ready=1, mem_we=0, mem_addr=0, mem_wd=0, ld_hit=0, ld_stall=0. ld_data follows mem_rd.
- Reset mid-operation discards all buffered stores without writing them. No partial write may occur: mem_we is forced to 0 while rst_n=0.
- Continuous loads cannot starve drains indefinitely. Once the buffer is full, drains win and loads stall until count<DEPTH.

## Configuration
- STBUF_FORWARD_EN defined: forwarding is enabled as described under Operation.
- STBUF_FORWARD_EN undefined:
  - ld_hit is tied to 0.
  - A load whose word index matches any valid entry asserts ld_stall. The drain takes the port that cycle, even if the buffer is not full, and continues until no matching entry remains.
  - Non-matching loads behave as with forwarding enabled.

## Test plan
- Reset then single store: store addr 0x10, data {6,5,4,3,2,1}, no loads. Required: count=1 after one edge; the next cycle has mem_we=1, mem_addr=0x10, mem_wd={6,5,4,3,2,1}; count=0 and empty=1 afterwards.
- Forwarding youngest: stores 0x20←{1,1,1,1,1,1} then 0x20←{9,9,9,9,9,9} with ld_req held. Then load 0x20. Required: ld_hit=1, ld_data={9,...}. After both drain, memory at 0x20 holds {9,...}.
- Word-index match: buffer holds 0x40. Load 0x43, then load 0x44. Required: 0x43 gives ld_hit=1; 0x44 gives ld_hit=0 and ld_data=mem_rd.
- Full with loads: four stores, then ld_req held continuously. Required: st_ready=0 while count=4; ld_stall=1 and mem_we=1 for one cycle; count drops to 3, then ld_stall=0 and the load is serviced.
- Wrap-around with simultaneous enqueue and drain: 10 back-to-back stores to 0x0..0x24 with no loads. Required: memory writes occur in order, count never exceeds 2, and the pointers wrap correctly.
- Reset mid-operation: three buffered stores, assert rst_n=0 for one cycle. Required: count=0, mem_we=0, and none of the three writes appears in memory. Without STBUF_FORWARD_EN: a load matching a buffered entry stalls until that entry drains, then returns mem_rd.
